ones_count_sched: RTL

Round-robin scheduler that shares one bit-count datapath (the N-bit ASM ones-counter with `data`/`s`/`Result` interface) between two requesters. It arbitrates requests, runs the datapath's load/start/done handshake for the winner, and returns the tagged result. It sits between the requesters and a single datapath instance; the datapath itself is external.

---
 rtl/ones_count_sched.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/ones_count_sched.sv
// ones_count_sched: round-robin scheduler that shares one external ones-counter
// datapath (data/s/result/done handshake) between two requesters and returns
// the tagged count.
// Optional feature: define OCS_TIMEOUT_EN to enable the RUN-state watchdog
// (limit TMO cycles; a timed-out job returns all ones with rsp_err set).
module ones_count_sched #(
  parameter int unsigned N   = 8,
  parameter int unsigned TMO = 2 * N + 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         req0,
  input  logic         req1,
  input  logic [N-1:0] data0,
  input  logic [N-1:0] data1,
  output logic         gnt0,
  output logic         gnt1,
  output logic         rsp_valid,
  output logic         rsp_id,
  output logic [N-1:0] rsp_result,
  output logic         rsp_err,
  output logic [N-1:0] dp_data,
  output logic         dp_s,
  input  logic [N-1:0] dp_result,
  input  logic         dp_done,
  output logic [1:0]   st,
  output logic         busy
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    LOAD = 2'b01,
    RUN  = 2'b10,
    DONE = 2'b11
  } state_t;

  state_t state;
  logic   lp;      // last-served requester
  logic   cur_id;  // requester owning the job in flight

  logic         any_req_c;
  logic         win_c;
  logic [N-1:0] win_data_c;

  assign st = state;

  // Round-robin pick: on a tie the requester not served last wins.
  always_comb begin
    any_req_c  = req0 | req1;
    win_c      = (req0 & req1) ? ~lp : req1;
    win_data_c = win_c ? data1 : data0;
  end

`ifdef OCS_TIMEOUT_EN
  localparam int unsigned CW = (TMO > 1) ? $clog2(TMO + 1) : 1;
  logic [CW-1:0] tmo_cnt;
`else
  // Without the watchdog there is never an error to report.
  logic unused_tmo;
  assign unused_tmo = (TMO != 0);
  assign rsp_err    = 1'b0;
`endif

  // Scheduler FSM with all outputs registered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      lp         <= 1'b1;
      cur_id     <= 1'b0;
      gnt0       <= 1'b0;
      gnt1       <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_result <= '0;
      dp_data    <= '0;
      dp_s       <= 1'b0;
      busy       <= 1'b0;
`ifdef OCS_TIMEOUT_EN
      rsp_err    <= 1'b0;
      tmo_cnt    <= '0;
`endif
    end else begin
      gnt0      <= 1'b0;
      gnt1      <= 1'b0;
      rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (any_req_c) begin
            state   <= LOAD;
            busy    <= 1'b1;
            lp      <= win_c;
            cur_id  <= win_c;
            dp_data <= win_data_c;
            dp_s    <= 1'b0;
            gnt0    <= ~win_c;
            gnt1    <= win_c;
          end
        end
        LOAD: begin
          state <= RUN;
          dp_s  <= 1'b1;
`ifdef OCS_TIMEOUT_EN
          tmo_cnt <= '0;
`endif
        end
        RUN: begin
          if (dp_done) begin
            state      <= DONE;
            dp_s       <= 1'b0;
            rsp_valid  <= 1'b1;
            rsp_id     <= cur_id;
            rsp_result <= dp_result;
`ifdef OCS_TIMEOUT_EN
            rsp_err    <= 1'b0;
          end else if (tmo_cnt == CW'(TMO - 1)) begin
            // Watchdog expiry: release the datapath and report a failed job.
            state      <= DONE;
            dp_s       <= 1'b0;
            rsp_valid  <= 1'b1;
            rsp_id     <= cur_id;
            rsp_result <= '1;
            rsp_err    <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt + CW'(1);
`endif
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          dp_s  <= 1'b0;
        end
      endcase
    end
  end

endmodule
